// File: rtl/dp_byte_ram_pkg.sv
// Shared types and helpers for the dual-port byte-enable RAM.
package dp_ram_pkg;

  localparam int unsigned MAX_LATENCY = 4;
  localparam int unsigned DEF_DATA_W  = 32;

  // Pipeline stage for the default word width; width-generic users rebuild
  // the same layout locally and pass it through the pipe's type parameter.
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DEF_DATA_W-1:0] data;
  } rsp_stage_t;

  function automatic logic [7:0] merge_lane(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       we);
    return we ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dp_byte_ram_if.sv
// Request/response bus for dp_byte_ram: port A fetch (read-only), port B load/store.
interface dp_byte_ram_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
);
  logic                  a_req;
  logic [ADDR_W-1:0]     a_addr;
  logic                  a_rvalid;
  logic [DATA_W-1:0]     a_rdata;
  logic                  a_err;
  logic                  b_req;
  logic [DATA_W/8-1:0]   b_we;
  logic [ADDR_W-1:0]     b_addr;
  logic [DATA_W-1:0]     b_wdata;
  logic                  b_rvalid;
  logic [DATA_W-1:0]     b_rdata;
  logic                  b_err;

  modport master (
    output a_req, a_addr, b_req, b_we, b_addr, b_wdata,
    input  a_rvalid, a_rdata, a_err, b_rvalid, b_rdata, b_err
  );

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_addr, b_wdata,
    output a_rvalid, a_rdata, a_err, b_rvalid, b_rdata, b_err
  );
endinterface

// File: rtl/dp_byte_ram_rsp_pipe.sv
// LATENCY-deep response delay line with synchronous reset; stage 0 is the array read register.
module dp_ram_rsp_pipe
  import dp_ram_pkg::*;
#(
  parameter type         T       = rsp_stage_t,
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst,
  input  T     stage_i,
  output T     stage_o
);

  T pipe_q [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= stage_i;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign stage_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/dp_byte_ram.sv
// True-dual-port byte-enable data RAM with configurable read latency and range check.
// Define DP_RAM_FWD_EN for write-first A/B same-address bypass; default is read-first.
module dp_byte_ram
  import dp_ram_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 65536,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 1
) (
  input logic          clk,
  input logic          rst,
  dp_byte_ram_if.slave bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } stage_t;

  if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_chk_data_w
    $error("dp_byte_ram: DATA_W must be a non-zero multiple of 8");
  end
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_chk_latency
    $error("dp_byte_ram: LATENCY must be in 1..4");
  end
  if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_chk_addr_w
    $error("dp_byte_ram: 2**ADDR_W must cover DEPTH");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              a_oor, b_oor, b_wr;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic [DATA_W-1:0] a_old, b_old, b_merged, a_word;
  stage_t            a_stage_d, b_stage_d, a_stage_q, b_stage_q;

  assign a_oor = 64'(bus.a_addr) >= 64'(DEPTH);
  assign b_oor = 64'(bus.b_addr) >= 64'(DEPTH);
  assign a_idx = bus.a_addr[IDX_W-1:0];
  assign b_idx = bus.b_addr[IDX_W-1:0];
  assign a_old = mem_q[a_idx];
  assign b_old = mem_q[b_idx];

  always_comb begin
    b_merged = b_old;
    for (int unsigned i = 0; i < NB; i++) begin
      b_merged[8*i +: 8] = merge_lane(b_old[8*i +: 8], bus.b_wdata[8*i +: 8], bus.b_we[i]);
    end
  end

  // Requests seen while rst is high are dropped, writes included.
  assign b_wr = ~rst & bus.b_req & ~b_oor & (|bus.b_we);

  always_ff @(posedge clk) begin
    if (b_wr) mem_q[b_idx] <= b_merged;
  end

`ifdef DP_RAM_FWD_EN
  assign a_word = (b_wr && !a_oor && (bus.a_addr == bus.b_addr)) ? b_merged : a_old;
`else
  assign a_word = a_old;
`endif

  always_comb begin
    a_stage_d.valid = bus.a_req;
    a_stage_d.err   = bus.a_req & a_oor;
    a_stage_d.data  = (bus.a_req && !a_oor) ? a_word : '0;
    b_stage_d.valid = bus.b_req;
    b_stage_d.err   = bus.b_req & b_oor;
    b_stage_d.data  = (bus.b_req && !b_oor) ? b_old : '0;
  end

  dp_ram_rsp_pipe #(.T(stage_t), .LATENCY(LATENCY)) u_a_pipe (
    .clk     (clk),
    .rst     (rst),
    .stage_i (a_stage_d),
    .stage_o (a_stage_q)
  );

  dp_ram_rsp_pipe #(.T(stage_t), .LATENCY(LATENCY)) u_b_pipe (
    .clk     (clk),
    .rst     (rst),
    .stage_i (b_stage_d),
    .stage_o (b_stage_q)
  );

  assign bus.a_rvalid = a_stage_q.valid;
  assign bus.a_err    = a_stage_q.err;
  assign bus.a_rdata  = a_stage_q.data;
  assign bus.b_rvalid = b_stage_q.valid;
  assign bus.b_err    = b_stage_q.err;
  assign bus.b_rdata  = b_stage_q.data;

endmodule

// File: tb/tb_dp_byte_ram.sv
// Scoreboard bench for dp_byte_ram (DEPTH=1000, LATENCY=3); honours DP_RAM_FWD_EN.
module tb_dp_byte_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1000;
  localparam int unsigned LAT   = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dp_byte_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dp_byte_ram #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int unsigned   stamp;
  } exp_t;

  exp_t          aq[$];
  exp_t          bq[$];
  logic [DW-1:0] model [int];
  int unsigned   cyc = 0;
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [DW/8-1:0] we);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < DW/8; i++) if (we[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] mrd(input logic [AW-1:0] a);
    return model.exists(int'(a)) ? model[int'(a)] : '0;
  endfunction

  // One issue cycle: drive both ports, predict responses, update the model.
  task automatic step(input logic ar, input logic [AW-1:0] aa, input logic br,
                      input logic [DW/8-1:0] bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    exp_t e;
    bus.a_req = ar;  bus.a_addr = aa;
    bus.b_req = br;  bus.b_we = bw;  bus.b_addr = ba;  bus.b_wdata = bd;
    if (!rst) begin
      if (ar) begin
        e.stamp = cyc + LAT;
        e.err   = (aa >= DEPTH);
        e.data  = e.err ? '0 : mrd(aa);
`ifdef DP_RAM_FWD_EN
        if (br && bw != 0 && ba == aa && !e.err) e.data = merge(e.data, bd, bw);
`endif
        aq.push_back(e);
      end
      if (br) begin
        e.stamp = cyc + LAT;
        e.err   = (ba >= DEPTH);
        e.data  = e.err ? '0 : mrd(ba);
        bq.push_back(e);
        if (bw != 0 && !e.err) model[int'(ba)] = merge(mrd(ba), bd, bw);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic bwr(input logic [AW-1:0] a, input logic [3:0] we, input logic [DW-1:0] d);
    step(1'b0, '0, 1'b1, we, a, d);
  endtask

  task automatic ard(input logic [AW-1:0] a);
    step(1'b1, a, 1'b0, '0, '0, '0);
  endtask

  task automatic brd(input logic [AW-1:0] a);
    step(1'b0, '0, 1'b1, '0, a, '0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_a_rvalid"}, bus.a_rvalid, 0);
    check_eq({tag, "_a_rdata"},  bus.a_rdata,  0);
    check_eq({tag, "_a_err"},    bus.a_err,    0);
    check_eq({tag, "_b_rvalid"}, bus.b_rvalid, 0);
    check_eq({tag, "_b_rdata"},  bus.b_rdata,  0);
    check_eq({tag, "_b_err"},    bus.b_err,    0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.a_rvalid) begin
        if (aq.size() == 0) check_eq("a_unexpected_rvalid", bus.a_rvalid, 0);
        else begin
          e = aq.pop_front();
          check_eq("a_rdata", bus.a_rdata, e.data);
          check_eq("a_err",   bus.a_err,   e.err);
          check_eq("a_lat",   cyc,         e.stamp);
        end
      end else begin
        check_eq("a_idle_rdata", bus.a_rdata, 0);
        check_eq("a_idle_err",   bus.a_err,   0);
        if (aq.size() != 0 && aq[0].stamp <= cyc) begin
          check_eq("a_missing_rvalid", bus.a_rvalid, 1);
          void'(aq.pop_front());
        end
      end
      if (bus.b_rvalid) begin
        if (bq.size() == 0) check_eq("b_unexpected_rvalid", bus.b_rvalid, 0);
        else begin
          e = bq.pop_front();
          check_eq("b_rdata", bus.b_rdata, e.data);
          check_eq("b_err",   bus.b_err,   e.err);
          check_eq("b_lat",   cyc,         e.stamp);
        end
      end else begin
        check_eq("b_idle_rdata", bus.b_rdata, 0);
        check_eq("b_idle_err",   bus.b_err,   0);
        if (bq.size() != 0 && bq[0].stamp <= cyc) begin
          check_eq("b_missing_rvalid", bus.b_rvalid, 1);
          void'(bq.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.a_req = 1'b0; bus.a_addr = '0;
    bus.b_req = 1'b0; bus.b_we = '0; bus.b_addr = '0; bus.b_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    mon_en = 1'b1;
    rst = 1'b0;

    // Full write then fetch.
    bwr(16'h0030, 4'hF, 32'h0000_0000);
    bwr(16'h0010, 4'hF, 32'hDEAD_BEEF);
    ard(16'h0010);

    // Byte-masked write: expect 0xDE22BE44 on the read-back.
    bwr(16'h0020, 4'hF, 32'hDEAD_BEEF);
    bwr(16'h0020, 4'b0101, 32'h1122_3344);
    brd(16'h0020);

    // Range boundary at DEPTH.
    bwr(16'd999, 4'hF, 32'h1234_5678);
    bwr(16'd1000, 4'hF, 32'hAAAA_5555);
    brd(16'd1000);
    brd(16'd999);
    ard(16'd1000);
    ard(16'hFFFF);

    // Same-cycle A read / B write collision.
    step(1'b1, 16'h0030, 1'b1, 4'b0011, 16'h0030, 32'hCAFE_F00D);
    ard(16'h0030);

    // Back-to-back fetches with concurrent B reads.
    for (int i = 0; i < 8; i++) bwr(16'h0040 + 16'(i), 4'hF, $urandom);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0040 + 16'(i), 1'b1, 4'h0, 16'h0047 - 16'(i), '0);

    // Mixed random traffic over a small window, with collisions and out-of-range hits.
    for (int i = 0; i < 8; i++) bwr(16'h0100 + 16'(i), 4'hF, $urandom);
    for (int i = 0; i < 60; i++) begin
      logic [AW-1:0] aa, ba;
      aa = ($urandom_range(0, 9) == 0) ? 16'(DEPTH + $urandom_range(0, 3)) : 16'h0100 + 16'($urandom_range(0, 7));
      ba = ($urandom_range(0, 9) == 0) ? 16'(DEPTH + $urandom_range(0, 3)) : 16'h0100 + 16'($urandom_range(0, 7));
      step(1'($urandom_range(0, 1)), aa, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ba, $urandom);
    end
    idle(LAT + 1);

    // Reset while two fetches are in flight; the write presented during reset is dropped.
    bwr(16'h0050, 4'hF, 32'h0102_0304);
    ard(16'h0010);
    ard(16'h0020);
    rst = 1'b1;
    bus.a_req = 1'b1; bus.a_addr = 16'h0010;
    bus.b_req = 1'b1; bus.b_we = 4'hF; bus.b_addr = 16'h0050; bus.b_wdata = 32'hBAD0_BAD0;
    @(posedge clk);
    aq.delete();
    bq.delete();
    @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b0;
    step(1'b1, 16'h0050, 1'b1, 4'h0, 16'h0050, '0);
    idle(LAT + 2);

    check_eq("a_drain", aq.size(), 0);
    check_eq("b_drain", bq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
